// File: rtl/frame_capture.sv
// frame_capture: stores one frame of sobel-processed pixels
// into a linear memory at row*IMG_WIDTH+col.
module frame_capture #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int ADDR_W     = 16
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic [7:0]        red_i,
  input  logic [7:0]        green_i,
  input  logic [7:0]        blue_i,
  input  logic              done_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [23:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overflow_o
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMPLETE
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [23:0]         wdata_q, wdata_d;
  logic                fdone_q, fdone_d;
  logic                ovf_q, ovf_d;

  // Next-state, counter and registered-output logic.
  // The final pixel's write lands in COMPLETE, which is
  // why frame_done is registered alongside the write.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    fdone_d = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CAPTURE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          ovf_d   = 1'b0;
        end else if (done_i) begin
          ovf_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (done_i) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = {red_i, green_i, blue_i};
          addr_d  = addr_q + ADDR_W'(1);
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              addr_d  = '0;
              state_d = S_COMPLETE;
              fdone_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_COMPLETE: begin
        state_d = S_IDLE;
        if (done_i) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and outputs; reset wins over everything.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      fdone_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      fdone_q <= fdone_d;
      ovf_q   <= ovf_d;
    end
  end

  assign mem_we_o     = we_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = fdone_q;
  assign overflow_o   = ovf_q;

endmodule
